ram_cmd_master: RTL and testbench
=================================

// Module: ram_cmd_master
// PURPOSE
//  Command-driven initiator for the single-port RW RAM (SEL=1 write, SEL=0 registered read).
//  - Accepts write / read / clear-all / checksum-scan commands on a valid/ready port.
//  - Sequences the RAM control pins and returns read or checksum results on a held response port.
//  - Sits between the user/test logic and the RAM; the RAM's own reset pin is not driven by this block.
// PARAMETERS
//  ADDR_WIDTH  2  RAM address bits; DEPTH = 1<<ADDR_WIDTH words
//  DATA_WIDTH  4  RAM word width
// PORTS
//  clk        in   1                      clock, all logic on posedge
//  reset      in   1                      synchronous, active-high
//  cmd_valid  in   1                      command offered
//  cmd_ready  out  1                      block accepts a command this cycle
//  cmd_op     in   2                      00 WRITE, 01 READ, 10 CLEAR, 11 SCAN
//  cmd_addr   in   ADDR_WIDTH             target address (WRITE/READ only)
//  cmd_data   in   DATA_WIDTH             write data (WRITE only)
//  rsp_valid  out  1                      response available
//  rsp_ready  in   1                      consumer takes response
//  rsp_data   out  DATA_WIDTH+ADDR_WIDTH  read word (zero-extended) or checksum
//  mem_sel    out  1                      to RAM SEL
//  mem_addr   out  ADDR_WIDTH             to RAM Addr
//  mem_din    out  DATA_WIDTH             to RAM Din
//  mem_dout   in   DATA_WIDTH             from RAM Dout, valid the cycle after a read address is presented
// BEHAVIOUR
//  - Reset: state IDLE; rsp_valid=0; rsp_data=0; counter=0; accumulator=0.
//  - Reset outputs: mem_sel gated to 0 while reset=1; mem_addr=0; mem_din=0.
//  - Reset mid-operation: aborts immediately; a partial CLEAR leaves higher words untouched; a pending response is dropped.
//  - Command handshake: cmd_ready=1 only in IDLE; accept on cmd_valid&&cmd_ready; latch op/addr/data.
//  - WRITE: 1 cycle with mem_sel=1, mem_addr=addr, mem_din=data -> IDLE. No response.
//  - READ: RD_ADDR (mem_sel=0, mem_addr=addr) -> RD_CAP (rsp_data<={0,mem_dout}) -> RESP.
//    rsp_valid rises 2 cycles after acceptance.
//  - CLEAR: counter 0..DEPTH-1, one word/cycle, mem_sel=1, mem_din=0 -> IDLE after last word.
//    DEPTH cycles, no response.
//  - SCAN: present addr k in cycle k (k=0..DEPTH-1, mem_sel=0); accumulate mem_dout in cycles 1..DEPTH.
//    After the DEPTH+1 cycle, rsp_data = sum mod 2^(DATA_WIDTH+ADDR_WIDTH) (cannot overflow) -> RESP.
//  - RESP: rsp_valid=1, rsp_data stable until rsp_ready=1; on handshake rsp_valid=0 -> IDLE.
//    cmd_ready=0 throughout RESP.
//  - Counter wrap: counter is ADDR_WIDTH bits; end detected at counter==DEPTH-1, never by overflow.
//  - Outside WRITE/CLEAR: mem_sel=0; mem_addr/mem_din are 0 in IDLE and RESP.
//  - Memory-side outputs are combinational from state/latched registers; no extra pipeline stage.
//  - Back-to-back: a command accepted in the cycle WRITE/CLEAR returns to IDLE is legal.
//    A READ right after a WRITE to the same address returns the new data.
//  - States: IDLE, WRITE, RD_ADDR, RD_CAP, CLEAR, SCAN, RESP.
// STRUCTURE
//  - Package ram_cmd_pkg: op_e enum (OP_WRITE, OP_READ, OP_CLEAR, OP_SCAN), state_e enum,
//    localparam RSP_WIDTH = DATA_WIDTH+ADDR_WIDTH.
//  - Single module, no sub-module.
//  - The bench instantiates the existing RW RAM with reset tied low and connects mem_* to SEL/Addr/Din/Dout.
// TESTING
//  1. reset 1 cycle -> cmd_ready=1, rsp_valid=0, mem_sel=0.
//     WRITE addr 2 data 4'hA -> one mem_sel pulse, addr=2, din=A.
//  2. READ addr 2 after case 1 -> rsp_valid 2 cycles after accept, rsp_data=6'h0A.
//     Hold rsp_ready=0 for 3 cycles -> data stable, cmd_ready=0.
//  3. WRITE 0..3 = F,F,F,F; SCAN -> rsp_data=6'h3C after DEPTH+1 cycles.
//  4. WRITE 0..3 = 1,2,3,4; CLEAR -> 4 consecutive mem_sel cycles with addr 0,1,2,3, din=0.
//     Then READ each address -> 0; SCAN -> 0.
//  5. CLEAR with reset asserted in its 2nd cycle -> mem_sel low that cycle; IDLE next cycle.
//     Addr 0 reads 0; addr 2,3 keep their old values.
//  6. cmd_valid held high with back-to-back WRITE 1=7, then READ 1 -> READ accepted the cycle after WRITE.
//     rsp_data=6'h07; no command accepted while rsp_valid=1.

Source files
------------

// File: rtl/ram_cmd_master_pkg.sv
// ram_cmd_pkg: shared types and sizing constants for the RAM command master.
// Contents:
//   ADDR_WIDTH / DATA_WIDTH  default RAM geometry
//   RSP_WIDTH                response width (wide enough for a full-memory checksum)
//   DEPTH                    number of RAM words
//   op_e                     command opcodes carried on cmd_op
//   state_e                  sequencer states
package ram_cmd_pkg;

  localparam int ADDR_WIDTH = 2;
  localparam int DATA_WIDTH = 4;
  localparam int RSP_WIDTH  = DATA_WIDTH + ADDR_WIDTH;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_SCAN  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_CAP,
    CLEAR,
    SCAN,
    RESP
  } state_e;

endpackage

// File: rtl/ram_cmd_master_if.sv
// ram_cmd_if: command and response handshake bundle of the RAM command master.
// Signals:
//   cmd_valid / cmd_ready   command handshake
//   cmd_op                  WRITE / READ / CLEAR / SCAN
//   cmd_addr / cmd_data     target address and write data
//   rsp_valid / rsp_ready   response handshake
//   rsp_data                zero-extended read word or checksum
// Modports:
//   master  the user/test logic issuing commands and consuming responses
//   slave   the command master block itself
interface ram_cmd_if #(
  parameter int ADDR_WIDTH = ram_cmd_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_cmd_pkg::DATA_WIDTH
);
  import ram_cmd_pkg::*;

  logic                             cmd_valid;
  logic                             cmd_ready;
  op_e                              cmd_op;
  logic [ADDR_WIDTH-1:0]            cmd_addr;
  logic [DATA_WIDTH-1:0]            cmd_data;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ram_cmd_master.sv
// ram_cmd_master: command-driven initiator for a single-port RAM
// (SEL=1 writes, SEL=0 performs a registered read, data valid next cycle).
// Executes WRITE, READ, CLEAR (zero every word) and SCAN (sum of all words),
// returning READ/SCAN results on a held response port.
// Ports:
//   clk       clock, all logic on posedge
//   reset     synchronous, active-high; aborts any operation in progress
//   bus       ram_cmd_if.slave: cmd_* command handshake, rsp_* response handshake
//   mem_sel   RAM SEL, high only while writing (forced low during reset)
//   mem_addr  RAM address
//   mem_din   RAM write data
//   mem_dout  RAM read data, valid the cycle after a read address
module ram_cmd_master #(
  parameter int ADDR_WIDTH = ram_cmd_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_cmd_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_cmd_if.slave              bus,
  output logic                  mem_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);
  import ram_cmd_pkg::*;

  localparam int RSP_W = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  tail;
  logic [RSP_W-1:0]      acc;
  logic [RSP_W-1:0]      rsp_q;
  logic [RSP_W-1:0]      dout_ext;
  logic                  cmd_ready_c;
  logic                  accept;

  assign dout_ext = {{ADDR_WIDTH{1'b0}}, mem_dout};
  assign accept   = bus.cmd_valid && cmd_ready_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory-side pins are decoded straight from the state and latched
  // registers, so the RAM sees them in the same cycle as the state.
  always_comb begin
    state_nxt   = state;
    cmd_ready_c = 1'b0;
    mem_sel     = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_WRITE: state_nxt = WRITE;
            OP_READ:  state_nxt = RD_ADDR;
            OP_CLEAR: state_nxt = CLEAR;
            OP_SCAN:  state_nxt = SCAN;
          endcase
        end
      end
      WRITE: begin
        mem_sel   = 1'b1;
        mem_addr  = addr_q;
        mem_din   = data_q;
        state_nxt = IDLE;
      end
      RD_ADDR: begin
        mem_addr  = addr_q;
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        state_nxt = RESP;
      end
      CLEAR: begin
        mem_sel  = 1'b1;
        mem_addr = cnt;
        if (cnt == LAST) begin
          state_nxt = IDLE;
        end
      end
      SCAN: begin
        mem_addr = cnt;
        if (tail) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // A reset landing mid-CLEAR must not write the word in flight.
    if (reset) begin
      cmd_ready_c = 1'b0;
      mem_sel     = 1'b0;
      mem_addr    = '0;
      mem_din     = '0;
    end
  end

  // SCAN spends DEPTH+1 cycles: addresses 0..DEPTH-1 are presented while the
  // word from the previous address is summed, and a final tail cycle adds the
  // last word. The counter never wraps to mark the end; the tail flag does.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      cnt    <= '0;
      tail   <= 1'b0;
      acc    <= '0;
      rsp_q  <= '0;
    end else begin
      if (accept) begin
        addr_q <= bus.cmd_addr;
        data_q <= bus.cmd_data;
        cnt    <= '0;
        tail   <= 1'b0;
        acc    <= '0;
      end
      case (state)
        RD_CAP: begin
          rsp_q <= dout_ext;
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
        end
        SCAN: begin
          if (tail) begin
            rsp_q <= acc + dout_ext;
            tail  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
          end else begin
            if (cnt != '0) begin
              acc <= acc + dout_ext;
            end
            if (cnt == LAST) begin
              tail <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.rsp_valid = (state == RESP) && !reset;
  assign bus.rsp_data  = rsp_q;

endmodule

// File: tb/tb_ram_cmd_master.sv
// tb_ram_cmd_master: self-checking bench for ram_cmd_master.
// Contains a behavioural model of the registered-read RAM, a reference memory
// image updated as commands are issued, and a response scoreboard checked by
// an independent monitor.
module tb_ram_cmd_master;
  import ram_cmd_pkg::*;

  typedef struct {
    logic [RSP_WIDTH-1:0] data;
    int                   lat;
  } exp_t;

  typedef struct {
    int                    cyc;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
  } mem_ev_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  mem_sel;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  logic [DATA_WIDTH-1:0] ram_arr [DEPTH];
  logic [DATA_WIDTH-1:0] model   [DEPTH];

  exp_t    exp_q[$];
  mem_ev_t mem_log[$];
  int      accept_log[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_accept = 0;
  bit   hold_ready = 1'b0;
  logic prev_valid = 1'b0;
  logic [RSP_WIDTH-1:0] prev_data = '0;

  ram_cmd_if bus ();

  ram_cmd_master dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .mem_sel  (mem_sel),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, reset pin tied low: write when SEL, else registered read.
  always @(posedge clk) begin
    if (mem_sel) begin
      ram_arr[mem_addr] <= mem_din;
    end else begin
      mem_dout <= ram_arr[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Consumer side: random back-pressure unless a test pins rsp_ready low.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready) bus.rsp_ready = 1'b0;
      else bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: logs accepts and RAM writes, checks responses against the
  // scoreboard, their hold stability and the response latency.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        last_accept = cyc;
        accept_log.push_back(cyc);
      end
      if (mem_sel) begin
        mem_log.push_back('{cyc, mem_addr, mem_din});
      end
      if (bus.rsp_valid) begin
        checkOutput("no_cmd_in_resp", int'(bus.cmd_ready), 0);
        if (prev_valid) begin
          checkOutput("rsp_stable", int'(bus.rsp_data), int'(prev_data));
        end else if (exp_q.size() == 0) begin
          checkOutput("rsp_expected", exp_q.size(), 1);
        end else begin
          // Latency is counted in edges after the accepting edge; the
          // negedge sample of the accept cycle sits one count earlier.
          checkOutput("rsp_latency", cyc - last_accept, exp_q[0].lat + 1);
        end
        if (bus.rsp_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("rsp_data", int'(bus.rsp_data), int'(e.data));
        end
      end
      prev_valid = bus.rsp_valid && !bus.rsp_ready;
      prev_data  = bus.rsp_data;
    end
  end

  task automatic sendCmd(input op_e op, input logic [ADDR_WIDTH-1:0] a,
                         input logic [DATA_WIDTH-1:0] d, input bit keep);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checkOutput("cmd_accept_timeout", int'(ok), 1);
    end
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  // Updates the reference memory image and queues the expected response.
  task automatic applyStimulus(input op_e op, input logic [ADDR_WIDTH-1:0] a,
                               input logic [DATA_WIDTH-1:0] d, input bit keep);
    int sum;
    case (op)
      OP_WRITE: model[a] = d;
      OP_READ:  exp_q.push_back('{RSP_WIDTH'(model[a]), 2});
      OP_CLEAR: for (int i = 0; i < DEPTH; i++) model[i] = '0;
      OP_SCAN: begin
        sum = 0;
        for (int i = 0; i < DEPTH; i++) sum += int'(model[i]);
        exp_q.push_back('{RSP_WIDTH'(sum % (1 << RSP_WIDTH)), DEPTH + 1});
      end
    endcase
    sendCmd(op, a, d, keep);
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.cmd_ready && !bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("idle_reached", int'(ok), 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;

    // Reset values
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_cmd_ready", int'(bus.cmd_ready), 1);
    checkOutput("rst_rsp_valid", int'(bus.rsp_valid), 0);
    checkOutput("rst_mem_sel", int'(mem_sel), 0);
    checkOutput("rst_rsp_data", int'(bus.rsp_data), 0);

    // Single WRITE produces exactly one SEL pulse
    mem_log.delete();
    applyStimulus(OP_WRITE, 2'd2, 4'hA, 1'b0);
    waitIdle();
    checkOutput("wr_pulses", mem_log.size(), 1);
    if (mem_log.size() == 1) begin
      checkOutput("wr_addr", int'(mem_log[0].addr), 2);
      checkOutput("wr_din", int'(mem_log[0].din), 10);
    end

    // READ with the response held off for three cycles
    hold_ready = 1'b1;
    applyStimulus(OP_READ, 2'd2, 4'h0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("rd_rsp_seen", int'(ok), 1);
    repeat (3) @(negedge clk);
    checkOutput("rd_held_data", int'(bus.rsp_data), 6'h0A);
    hold_ready = 1'b0;
    waitIdle();

    // All-ones memory checksum
    for (int i = 0; i < DEPTH; i++) applyStimulus(OP_WRITE, ADDR_WIDTH'(i), 4'hF, 1'b0);
    applyStimulus(OP_SCAN, 2'd0, 4'h0, 1'b0);
    waitIdle();

    // CLEAR sweeps every word on consecutive cycles
    for (int i = 0; i < DEPTH; i++) applyStimulus(OP_WRITE, ADDR_WIDTH'(i), DATA_WIDTH'(i + 1), 1'b0);
    waitIdle();
    mem_log.delete();
    applyStimulus(OP_CLEAR, 2'd0, 4'h0, 1'b0);
    waitIdle();
    checkOutput("clr_pulses", mem_log.size(), DEPTH);
    if (mem_log.size() == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) begin
        checkOutput("clr_addr", int'(mem_log[i].addr), i);
        checkOutput("clr_din", int'(mem_log[i].din), 0);
        checkOutput("clr_cycle", mem_log[i].cyc - mem_log[0].cyc, i);
      end
    end
    for (int i = 0; i < DEPTH; i++) applyStimulus(OP_READ, ADDR_WIDTH'(i), 4'h0, 1'b0);
    applyStimulus(OP_SCAN, 2'd0, 4'h0, 1'b0);
    waitIdle();

    // Reset in the second CLEAR cycle aborts the sweep
    applyStimulus(OP_WRITE, 2'd0, 4'h5, 1'b0);
    applyStimulus(OP_WRITE, 2'd1, 4'h6, 1'b0);
    applyStimulus(OP_WRITE, 2'd2, 4'h9, 1'b0);
    applyStimulus(OP_WRITE, 2'd3, 4'hC, 1'b0);
    waitIdle();
    mem_log.delete();
    sendCmd(OP_CLEAR, 2'd0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_sel", int'(mem_sel), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_idle", int'(bus.cmd_ready), 1);
    checkOutput("rst_mid_pulses", mem_log.size(), 1);
    model[0] = '0;
    applyStimulus(OP_READ, 2'd0, 4'h0, 1'b0);
    applyStimulus(OP_READ, 2'd1, 4'h0, 1'b0);
    applyStimulus(OP_READ, 2'd2, 4'h0, 1'b0);
    applyStimulus(OP_READ, 2'd3, 4'h0, 1'b0);
    waitIdle();

    // Back-to-back WRITE then READ with cmd_valid held high
    accept_log.delete();
    applyStimulus(OP_WRITE, 2'd1, 4'h7, 1'b1);
    applyStimulus(OP_READ, 2'd1, 4'h0, 1'b0);
    waitIdle();
    checkOutput("b2b_accepts", accept_log.size(), 2);
    if (accept_log.size() == 2) begin
      checkOutput("b2b_gap", accept_log[1] - accept_log[0], 2);
    end

    // Randomized command mix against the reference image
    for (int n = 0; n < 60; n++) begin
      applyStimulus(op_e'($urandom_range(0, 3)), ADDR_WIDTH'($urandom_range(0, DEPTH - 1)),
                    DATA_WIDTH'($urandom_range(0, (1 << DATA_WIDTH) - 1)),
                    1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    waitIdle();
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
